// File: rtl/canny_ctrl_pkg.sv
// canny_ctrl_pkg
// Shared types and constants for the Canny per-frame controller:
//   - ctrl_state_e : frame FSM states
//   - ADDR_*       : cfg register map
//   - THR_*_DEF    : threshold reset defaults
//   - thr_pair_t   : packed {high, low} threshold pair, matching the cfg
//                    addr 0 data layout
package canny_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    SKIP     = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] ADDR_THR  = 2'd0;  // {high[15:8], low[7:0]}
  localparam logic [1:0] ADDR_SKIP = 2'd1;  // skip ratio [3:0]
  localparam logic [1:0] ADDR_CTRL = 2'd2;  // bit0 enable
  localparam logic [1:0] ADDR_CLR  = 2'd3;  // bit0 write-1 clears err_geom

  localparam logic [7:0] THR_LOW_DEF  = 8'd40;
  localparam logic [7:0] THR_HIGH_DEF = 8'd100;

  typedef struct packed {
    logic [7:0] high;
    logic [7:0] low;
  } thr_pair_t;

endpackage

// File: rtl/vip_geom_checker.sv
// vip_geom_checker
// Frame edge detection plus per-line / per-frame geometry checking.
//   clk, rst_n      : pixel clock, synchronous active-low reset
//   vsync/href/clken: upstream video controls
//   chk_en          : qualifies the mismatch output (frame being passed)
//   vsync_d/href_d  : 1-cycle registered copies, reused by the parent as
//                     the first video pipeline stage
//   sof/eof         : combinational rising/falling edge of vsync
//   mismatch        : combinational; a completed line has a pixel count
//                     other than IMG_HDISP, or the frame ending this cycle
//                     has a line count other than IMG_VDISP
module vip_geom_checker #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  input  logic clken,
  input  logic chk_en,
  output logic vsync_d,
  output logic href_d,
  output logic sof,
  output logic eof,
  output logic mismatch
);

  localparam int HW = $clog2(IMG_HDISP + 1);
  localparam int VW = $clog2(IMG_VDISP + 1);
  localparam logic [HW-1:0] HDISP_C = HW'(IMG_HDISP);
  localparam logic [VW-1:0] VDISP_C = VW'(IMG_VDISP);

  logic [HW-1:0] pix_cnt;
  logic [VW-1:0] line_cnt;
  logic [VW-1:0] line_nxt;
  logic          href_fall;
  logic          pix_in;

  assign sof       = vsync & ~vsync_d;
  assign eof       = ~vsync & vsync_d;
  assign href_fall = href_d & ~href;
  assign pix_in    = href & clken;

  // A line may close on the same cycle vsync drops; the frame check must
  // see that last line, so compare against the post-increment value.
  assign line_nxt = (href_fall && line_cnt != '1) ? line_cnt + VW'(1) : line_cnt;

  assign mismatch = chk_en & ((href_fall & (pix_cnt != HDISP_C)) |
                              (eof & (line_nxt != VDISP_C)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
      if (sof) begin
        // keep a pixel that coincides with the start of frame
        pix_cnt  <= pix_in ? HW'(1) : '0;
        line_cnt <= '0;
      end else begin
        if (href_fall)
          pix_cnt <= '0;
        else if (pix_in && pix_cnt != '1)
          pix_cnt <= pix_cnt + HW'(1);
        line_cnt <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl
// Per-frame controller between the Gaussian filter and the Canny detector.
// Latches hysteresis thresholds at frame start, gates frames by a skip
// ratio, checks frame geometry and pulses frame_done after passed frames.
// Optional feature macro: CANNY_CTRL_FRAME_SKIP_EN (skip ratio + SKIP state).
// Ports:
//   clk, rst_n                 : pixel clock, synchronous active-low reset
//   cfg_wr/cfg_addr/cfg_wdata  : register port (see canny_ctrl_pkg ADDR_*)
//   per_frame_*/per_img_y      : upstream video
//   post_frame_*/post_img_y    : gated video, 2-cycle latency
//   thr_low/thr_high           : thresholds for the current frame
//   frame_done                 : 1-cycle pulse after each passed frame
//   err_geom                   : sticky geometry error
//   busy                       : frame being passed or skipped
module canny_frame_ctrl
  import canny_ctrl_pkg::*;
#(
  parameter int         IMG_HDISP    = 640,
  parameter int         IMG_VDISP    = 480,
  parameter logic [7:0] THR_LOW_RST  = THR_LOW_DEF,
  parameter logic [7:0] THR_HIGH_RST = THR_HIGH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_y,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  post_img_y,
  output logic [7:0]  thr_low,
  output logic [7:0]  thr_high,
  output logic        frame_done,
  output logic        err_geom,
  output logic        busy
);

  ctrl_state_e state;
  thr_pair_t   thr_sh;
  logic        enable;
`ifdef CANNY_CTRL_FRAME_SKIP_EN
  logic [3:0]  skip_ratio;
  logic [3:0]  skip_cnt;
`endif

  // first pipeline stage (vsync/href stage lives in the checker)
  logic        vsync_d, href_d, clken_d;
  logic [7:0]  y_d;
  logic        sof, eof, mismatch;
  logic        act;
  logic        clr_err;

  assign act     = (state == ACTIVE);
  assign busy    = (state == ACTIVE) || (state == SKIP);
  assign clr_err = cfg_wr && (cfg_addr == ADDR_CLR) && cfg_wdata[0];

  vip_geom_checker #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_geom (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (per_frame_vsync),
    .href     (per_frame_href),
    .clken    (per_frame_clken),
    .chk_en   (act),
    .vsync_d  (vsync_d),
    .href_d   (href_d),
    .sof      (sof),
    .eof      (eof),
    .mismatch (mismatch)
  );

  // Shadow registers: writable at any time, consumed only at frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_sh     <= '{high: THR_HIGH_RST, low: THR_LOW_RST};
      enable     <= 1'b0;
`ifdef CANNY_CTRL_FRAME_SKIP_EN
      skip_ratio <= 4'd0;
`endif
    end else if (cfg_wr) begin
      case (cfg_addr)
        ADDR_THR:  thr_sh     <= thr_pair_t'(cfg_wdata);
`ifdef CANNY_CTRL_FRAME_SKIP_EN
        ADDR_SKIP: skip_ratio <= cfg_wdata[3:0];
`endif
        ADDR_CTRL: enable     <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Frame FSM with registered video/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      thr_low          <= THR_LOW_RST;
      thr_high         <= THR_HIGH_RST;
      frame_done       <= 1'b0;
      err_geom         <= 1'b0;
      clken_d          <= 1'b0;
      y_d              <= 8'd0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_y       <= 8'd0;
`ifdef CANNY_CTRL_FRAME_SKIP_EN
      skip_cnt         <= 4'd0;
`endif
    end else begin
      clken_d <= per_frame_clken;
      y_d     <= per_img_y;

      // Stage 1 holds the sample that arrived with the SOF decision, so
      // gating stage 1 by the current state lines up with the frame.
      post_frame_vsync <= act & vsync_d;
      post_frame_href  <= act & href_d;
      post_frame_clken <= act & clken_d;
      post_img_y       <= act ? y_d : 8'd0;

      // clear first, then set, so a coincident set wins
      err_geom   <= (err_geom & ~clr_err) | mismatch;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
`ifdef CANNY_CTRL_FRAME_SKIP_EN
          // restart the decimation phase on every enable
          skip_cnt <= 4'd0;
`endif
          if (enable) state <= WAIT_SOF;
        end

        WAIT_SOF: begin
          if (!enable) begin
            state <= IDLE;
          end else if (sof) begin
`ifdef CANNY_CTRL_FRAME_SKIP_EN
            skip_cnt <= (skip_cnt >= skip_ratio) ? 4'd0 : skip_cnt + 4'd1;
            if (skip_cnt == 4'd0) begin
              state    <= ACTIVE;
              thr_low  <= thr_sh.low;
              thr_high <= thr_sh.high;
            end else begin
              state <= SKIP;
            end
`else
            state    <= ACTIVE;
            thr_low  <= thr_sh.low;
            thr_high <= thr_sh.high;
`endif
          end
        end

        ACTIVE: begin
          if (eof) begin
            frame_done <= 1'b1;
            state      <= enable ? WAIT_SOF : IDLE;
          end
        end

`ifdef CANNY_CTRL_FRAME_SKIP_EN
        SKIP: begin
          if (eof) state <= enable ? WAIT_SOF : IDLE;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// tb_canny_frame_ctrl
// Drives small frames with random pixel data and random clken gaps. A
// frame-level model decides which frames pass (enable at SOF, decimation
// by frame index), tracks shadow/active thresholds and the error flag, and
// the gated video stream is compared against the inputs two cycles earlier.
module tb_canny_frame_ctrl;
  localparam int H = 16;
  localparam int V = 8;
  localparam int EV_NONE = 0, EV_THR = 1, EV_DIS = 2, EV_RST = 3;
`ifdef CANNY_CTRL_FRAME_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        vs, hr, ce;
  logic [7:0]  y;
  logic        post_vs, post_hr, post_ce;
  logic [7:0]  post_y, thr_low, thr_high;
  logic        frame_done, err_geom, busy;

  canny_frame_ctrl #(
    .IMG_HDISP(H), .IMG_VDISP(V), .THR_LOW_RST(8'd40), .THR_HIGH_RST(8'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .per_img_y(y),
    .post_frame_vsync(post_vs), .post_frame_href(post_hr),
    .post_frame_clken(post_ce), .post_img_y(post_y),
    .thr_low(thr_low), .thr_high(thr_high), .frame_done(frame_done),
    .err_geom(err_geom), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit         m_en, m_err, cur_pass, mon_on, rst_chk;
  int         m_ratio, m_seen, dut_done;
  logic [7:0] m_sh_lo, m_sh_hi, m_lo, m_hi;
  logic [10:0] q[$];

  typedef struct {
    int          ratio;
    int          n;
    logic [15:0] thr;
    int          exp_done;
    logic [15:0] exp_thr;
  } row_t;
  row_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_err = 0; m_ratio = 0; m_seen = 0; cur_pass = 0;
    m_sh_lo = 8'd40; m_sh_hi = 8'd100; m_lo = 8'd40; m_hi = 8'd100;
  endtask

  task automatic model_wr(input logic [1:0] a, input logic [15:0] d);
    case (a)
      2'd0: begin m_sh_hi = d[15:8]; m_sh_lo = d[7:0]; end
      2'd1: if (SKIP_EN) m_ratio = int'(d[3:0]);
      2'd2: begin if (!d[0]) m_seen = 0; m_en = d[0]; end
      default: if (d[0]) m_err = 0;
    endcase
  endtask

  // negedge sampling: gated-stream check (2-cycle delay) and done counting
  task automatic samp();
    logic [10:0] e;
    bit p;
    @(negedge clk);
    if (mon_on) begin
      p = cur_pass & vs;
      q.push_back(p ? {vs, hr, ce, y} : 11'd0);
      if (q.size() > 2) begin
        e = q.pop_front();
        chk("pipe", {21'd0, post_vs, post_hr, post_ce, post_y}, {21'd0, e});
      end
      if (frame_done) dut_done++;
    end
    if (rst_chk) begin
      chk("reset_state", {2'd0, post_vs, post_hr, post_ce, post_y, frame_done,
                          err_geom, busy, thr_low, thr_high},
                         {2'd0, 3'b000, 8'd0, 3'b000, 8'd40, 8'd100});
      q.delete();
      mon_on  = 1;
      rst_chk = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
    cfg_wr = 0;
    if (!rst_n) begin rst_n = 1; rst_chk = 1; end
  endtask

  task automatic cyc(input logic v, input logic h, input logic c);
    vs = v; hr = h; ce = c; y = 8'($urandom);
    samp(); adv();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1; cfg_addr = a; cfg_wdata = d; model_wr(a, d);
    cyc(0, 0, 0);
  endtask

  task automatic drive_frame(input int bad_line, input int ev_line,
                             input int ev_kind, input logic [15:0] ev_data);
    bit seen, pass, first, c;
    logic [15:0] old;
    int npix, n;
    repeat (3) cyc(0, 0, 0);
    // start of frame: model decides the frame's fate
    seen = m_en; pass = 0;
    if (seen) begin
      pass = (m_seen % (m_ratio + 1)) == 0;
      m_seen++;
    end
    old = {m_hi, m_lo};
    if (pass) begin m_hi = m_sh_hi; m_lo = m_sh_lo; end
    cur_pass = pass;
    vs = 1; hr = 0; ce = 0; y = 8'($urandom);
    samp(); chk("thr_sof", {16'd0, thr_high, thr_low}, {16'd0, old}); adv();
    vs = 1; hr = 0; ce = 0; y = 8'($urandom);
    samp(); chk("thr_load", {16'd0, thr_high, thr_low}, {16'd0, m_hi, m_lo}); adv();
    for (int l = 0; l < V; l++) begin
      npix = (l == bad_line) ? H - 1 : H;
      n = 0; first = 1;
      while (n < npix) begin
        c = ($urandom_range(3) != 0);
        if (c) n++;
        vs = 1; hr = 1; ce = c; y = 8'($urandom);
        if (first && l == ev_line) begin
          case (ev_kind)
            EV_THR: begin cfg_wr = 1; cfg_addr = 2'd0; cfg_wdata = ev_data; model_wr(2'd0, ev_data); end
            EV_DIS: begin cfg_wr = 1; cfg_addr = 2'd2; cfg_wdata = 16'd0; model_wr(2'd2, 16'd0); end
            EV_RST: begin mon_on = 0; rst_n = 0; model_reset(); pass = 0; end
            default: ;
          endcase
        end
        samp();
        if (first && l == 0) chk("busy", {31'd0, busy}, {31'd0, seen});
        adv();
        first = 0;
      end
      cyc(1, 0, 0);
      cyc(1, 0, 0);
    end
    // end of frame
    if (pass && bad_line >= 0) m_err = 1;
    cyc(0, 0, 0);
    vs = 0; hr = 0; ce = 0; y = 8'($urandom);
    samp();
    chk("frame_done", {31'd0, frame_done}, {31'd0, pass});
    chk("err_eof", {31'd0, err_geom}, {31'd0, m_err});
    adv();
    vs = 0; y = 8'($urandom);
    samp(); chk("done_pulse", {31'd0, frame_done}, 32'd0); adv();
    cur_pass = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0] = '{ratio: 0,  n: 3, thr: 16'h6428, exp_done: 3,              exp_thr: 16'h6428};
    tbl[1] = '{ratio: 2,  n: 6, thr: 16'hFF00, exp_done: SKIP_EN ? 2 : 6, exp_thr: 16'hFF00};
    tbl[2] = '{ratio: 1,  n: 4, thr: 16'h1234, exp_done: SKIP_EN ? 2 : 4, exp_thr: 16'h1234};
    tbl[3] = '{ratio: 15, n: 3, thr: 16'h80C0, exp_done: SKIP_EN ? 1 : 3, exp_thr: 16'h80C0};

    model_reset();
    mon_on = 0; rst_chk = 0; dut_done = 0;
    cfg_wr = 0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
    vs = 0; hr = 0; ce = 0; y = 8'd0;
    rst_n = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);  // reset-state check happens here

    // thresholds written mid-frame only take effect at the next frame
    wr(2'd2, 16'd1);
    drive_frame(-1, 3, EV_THR, 16'h5A1E);
    chk("thr_mid_hold", {16'd0, thr_high, thr_low}, 32'h0000_6428);
    drive_frame(-1, -1, EV_NONE, 16'd0);
    chk("thr_next", {16'd0, thr_high, thr_low}, 32'h0000_5A1E);

    // short line: sticky error, then explicit clear
    drive_frame(3, -1, EV_NONE, 16'd0);
    chk("err_set", {31'd0, err_geom}, 32'd1);
    drive_frame(-1, -1, EV_NONE, 16'd0);
    chk("err_sticky", {31'd0, err_geom}, 32'd1);
    wr(2'd3, 16'd1);
    chk("err_clr", {31'd0, err_geom}, 32'd0);

    // disable mid-frame: current frame completes, next one blocked
    d0 = dut_done;
    drive_frame(-1, 4, EV_DIS, 16'd0);
    drive_frame(-1, -1, EV_NONE, 16'd0);
    chk("dis_done", 32'(dut_done - d0), 32'd1);
    chk("dis_busy", {31'd0, busy}, 32'd0);

    // reset mid-frame, then recovery
    wr(2'd2, 16'd1);
    drive_frame(-1, 5, EV_RST, 16'd0);
    wr(2'd2, 16'd1);
    d0 = dut_done;
    drive_frame(-1, -1, EV_NONE, 16'd0);
    chk("rst_recover_done", 32'(dut_done - d0), 32'd1);
    chk("rst_recover_err", {31'd0, err_geom}, 32'd0);
    chk("rst_recover_thr", {16'd0, thr_high, thr_low}, 32'h0000_6428);
    wr(2'd2, 16'd0);

    // decimation ratio / threshold table
    for (int i = 0; i < 4; i++) begin
      wr(2'd1, 16'(tbl[i].ratio));
      wr(2'd0, tbl[i].thr);
      wr(2'd2, 16'd1);
      d0 = dut_done;
      for (int f = 0; f < tbl[i].n; f++) drive_frame(-1, -1, EV_NONE, 16'd0);
      wr(2'd2, 16'd0);
      chk($sformatf("tbl%0d_done", i), 32'(dut_done - d0), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_thr", i), {16'd0, thr_high, thr_low}, {16'd0, tbl[i].exp_thr});
      chk($sformatf("tbl%0d_err", i), {31'd0, err_geom}, 32'd0);
    end

    repeat (4) cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
